// File: rtl/dm_port_if.sv
// Data-memory port bundle shared by the core, the host and the arbiter.
// The arbiter takes the slave modport. The core/host/memory side takes the master modport.
interface dm_port_if #(
  parameter int DMA_SIZE = 17,
  parameter int DMD_SIZE = 16
);
  logic                ps_dm_cslt;
  logic                ps_dm_wrb;
  logic [DMA_SIZE-1:0] dg_dm_add;
  logic [DMD_SIZE-1:0] bc_dt;
  logic                hst_req;
  logic                hst_wrb;
  logic [DMA_SIZE-1:0] hst_add;
  logic [DMD_SIZE-1:0] hst_wdt;
  logic [DMD_SIZE-1:0] dm_arb_rdt;
  logic                arb_dm_cslt;
  logic                arb_dm_wrb;
  logic [DMA_SIZE-1:0] arb_dm_add;
  logic [DMD_SIZE-1:0] arb_dm_wdt;
  logic                arb_ps_stall;
  logic                hst_ack;
  logic [DMD_SIZE-1:0] hst_rdt;

  modport slave (
    input  ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
    input  hst_req, hst_wrb, hst_add, hst_wdt, dm_arb_rdt,
    output arb_dm_cslt, arb_dm_wrb, arb_dm_add, arb_dm_wdt,
    output arb_ps_stall, hst_ack, hst_rdt
  );

  modport master (
    output ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
    output hst_req, hst_wrb, hst_add, hst_wdt, dm_arb_rdt,
    input  arb_dm_cslt, arb_dm_wrb, arb_dm_add, arb_dm_wdt,
    input  arb_ps_stall, hst_ack, hst_rdt
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory port between the core (default owner) and a host.
// The host steals a single cycle, and only when the core is idle or has starved it long enough.
module dm_port_arbiter #(
  parameter int DMA_SIZE   = 17,
  parameter int DMD_SIZE   = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic     clk,
  input  logic     rst,
  dm_port_if.slave bus
);

  typedef enum logic [1:0] {
    CORE       = 2'd0,
    HOST_ISSUE = 2'd1,
    HOST_DONE  = 2'd2
  } state_t;

  localparam int                CNT_W       = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  STARVE_LAST = CNT_W'(STARVE_MAX - 1);
  localparam logic [DMA_SIZE-1:0] ADD_ZERO  = {DMA_SIZE{1'b0}};
  localparam logic [DMD_SIZE-1:0] DATA_ZERO = {DMD_SIZE{1'b0}};

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    starve_cnt_r, starve_cnt_s;
  logic                host_wr_prev_r;
  logic                hst_wrb_r;
  logic [DMD_SIZE-1:0] hst_wdt_r;

  logic                dm_cslt_s;
  logic                dm_wrb_s;
  logic [DMA_SIZE-1:0] dm_add_s;
  logic [DMD_SIZE-1:0] dm_wdt_s;
  logic                stall_s;
  logic                ack_s;
  logic [DMD_SIZE-1:0] rdt_s;

  // Next state and starvation count; the count reaching its limit forces the host in
  always_comb begin
    state_s      = state_r;
    starve_cnt_s = starve_cnt_r;
    case (state_r)
      CORE: begin
        if (!bus.hst_req) begin
          starve_cnt_s = CNT_ZERO;
        end else if (!bus.ps_dm_cslt || (starve_cnt_r == STARVE_LAST)) begin
          state_s      = HOST_ISSUE;
          starve_cnt_s = CNT_ZERO;
        end else begin
          starve_cnt_s = starve_cnt_r + CNT_W'(1);
        end
      end
      HOST_ISSUE: state_s = HOST_DONE;
      HOST_DONE:  state_s = CORE;
      default: begin
        state_s      = CORE;
        starve_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State, starvation count, captured host op and previous-cycle write owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= CORE;
      starve_cnt_r   <= CNT_ZERO;
      host_wr_prev_r <= 1'b0;
      hst_wrb_r      <= 1'b0;
      hst_wdt_r      <= DATA_ZERO;
    end else begin
      state_r        <= state_s;
      starve_cnt_r   <= starve_cnt_s;
      host_wr_prev_r <= (state_r == HOST_ISSUE) && bus.hst_wrb;
      if (state_r == HOST_ISSUE) begin
        hst_wrb_r <= bus.hst_wrb;
        hst_wdt_r <= bus.hst_wdt;
      end
    end
  end

  // Port steering; write data trails the issue by one cycle, so it follows last cycle's owner
  always_comb begin
    dm_cslt_s = 1'b0;
    dm_wrb_s  = 1'b0;
    dm_add_s  = ADD_ZERO;
    dm_wdt_s  = DATA_ZERO;
    stall_s   = 1'b0;
    ack_s     = 1'b0;
    rdt_s     = DATA_ZERO;
    if (rst) begin
      dm_cslt_s = 1'b0;
    end else begin
      dm_cslt_s = bus.ps_dm_cslt;
      dm_wrb_s  = bus.ps_dm_wrb;
      dm_add_s  = bus.dg_dm_add;
      if (host_wr_prev_r) begin
        dm_wdt_s = hst_wdt_r;
      end else begin
        dm_wdt_s = bus.bc_dt;
      end
      case (state_r)
        CORE: stall_s = 1'b0;
        HOST_ISSUE: begin
          dm_cslt_s = 1'b1;
          dm_wrb_s  = bus.hst_wrb;
          dm_add_s  = bus.hst_add;
          stall_s   = 1'b1;
        end
        HOST_DONE: begin
          ack_s = 1'b1;
          if (hst_wrb_r) begin
            rdt_s = DATA_ZERO;
          end else begin
            rdt_s = bus.dm_arb_rdt;
          end
        end
        default: stall_s = 1'b0;
      endcase
    end
  end

  assign bus.arb_dm_cslt  = dm_cslt_s;
  assign bus.arb_dm_wrb   = dm_wrb_s;
  assign bus.arb_dm_add   = dm_add_s;
  assign bus.arb_dm_wdt   = dm_wdt_s;
  assign bus.arb_ps_stall = stall_s;
  assign bus.hst_ack      = ack_s;
  assign bus.hst_rdt      = rdt_s;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed and random checks of dm_port_arbiter.
// The reference is a model of who owns the memory port in each cycle.
module tb_dm_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_port_if #(.DMA_SIZE(AW), .DMD_SIZE(DW)) bus ();
  dm_port_arbiter #(.DMA_SIZE(AW), .DMD_SIZE(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: slot 0 = core owns the cycle, 1 = host address cycle, 2 = host completion cycle
  int          slot;
  int          core_wins;
  bit          last_host_wr;
  bit          held_wr;
  logic [DW-1:0] held_wdata;
  bit          ack_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic          e_cs, e_wr, e_st, e_ack;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_wd, e_rd;
    e_cs = 1'b0; e_wr = 1'b0; e_st = 1'b0; e_ack = 1'b0;
    e_ad = '0; e_wd = '0; e_rd = '0;
    if (!rst) begin
      e_cs  = (slot == 1) ? 1'b1 : bus.ps_dm_cslt;
      e_wr  = (slot == 1) ? bus.hst_wrb : bus.ps_dm_wrb;
      e_ad  = (slot == 1) ? bus.hst_add : bus.dg_dm_add;
      e_st  = (slot == 1);
      e_wd  = last_host_wr ? held_wdata : bus.bc_dt;
      e_ack = (slot == 2);
      e_rd  = (slot == 2 && !held_wr) ? bus.dm_arb_rdt : '0;
    end
    ack_seen = e_ack;
    check("cslt",  32'(bus.arb_dm_cslt),  32'(e_cs));
    check("wrb",   32'(bus.arb_dm_wrb),   32'(e_wr));
    check("add",   32'(bus.arb_dm_add),   32'(e_ad));
    check("wdt",   32'(bus.arb_dm_wdt),   32'(e_wd));
    check("stall", 32'(bus.arb_ps_stall), 32'(e_st));
    check("ack",   32'(bus.hst_ack),      32'(e_ack));
    check("rdt",   32'(bus.hst_rdt),      32'(e_rd));
  endtask

  task automatic advance_model();
    if (rst) begin
      slot = 0; core_wins = 0; last_host_wr = 1'b0;
    end else if (slot == 1) begin
      slot = 2; held_wr = bus.hst_wrb; held_wdata = bus.hst_wdt; last_host_wr = bus.hst_wrb;
    end else if (slot == 2) begin
      slot = 0; last_host_wr = 1'b0;
    end else begin
      last_host_wr = 1'b0;
      if (bus.hst_req && (!bus.ps_dm_cslt || core_wins == SM - 1)) begin
        slot = 1; core_wins = 0;
      end else if (!bus.hst_req) begin
        core_wins = 0;
      end else begin
        core_wins++;
      end
    end
  endtask

  task automatic drive_cycle(input logic r, input logic cs, input logic wr, input logic [AW-1:0] ad,
                             input logic [DW-1:0] bc, input logic hr, input logic hw,
                             input logic [AW-1:0] ha, input logic [DW-1:0] hd, input logic [DW-1:0] rd);
    @(negedge clk);
    rst = r;
    bus.ps_dm_cslt = cs; bus.ps_dm_wrb = wr; bus.dg_dm_add = ad; bus.bc_dt = bc;
    bus.hst_req = hr; bus.hst_wrb = hw; bus.hst_add = ha; bus.hst_wdt = hd; bus.dm_arb_rdt = rd;
    #1;
    check_model();
    advance_model();
  endtask

  initial begin
    int            grants;
    int            gap;
    bit            seen;
    logic [DW-1:0] bc;
    bit            h_pend, h_wr, r;
    logic [AW-1:0] h_add;
    logic [DW-1:0] h_wd;
    slot = 0; core_wins = 0; last_host_wr = 1'b0; held_wr = 1'b0; held_wdata = '0; ack_seen = 1'b0;
    rst = 1'b1;

    // Reset with every input active: all outputs must stay 0
    drive_cycle(1'b1, 1'b1, 1'b1, 17'h1FFFF, 16'hFFFF, 1'b1, 1'b1, 17'h1FFFF, 16'hFFFF, 16'hFFFF);
    drive_cycle(1'b1, 1'b1, 1'b1, 17'h1FFFF, 16'hFFFF, 1'b1, 1'b1, 17'h1FFFF, 16'hFFFF, 16'hFFFF);
    check("rst_wdt", 32'(bus.arb_dm_wdt), 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0);

    // Core-only write to 0x0000A, data 0xFFEE one cycle later
    drive_cycle(1'b0, 1'b1, 1'b1, 17'h0000A, 16'h0000, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0);
    check("core_add", 32'(bus.arb_dm_add), 32'h0000A);
    check("core_cslt", 32'(bus.arb_dm_cslt), 32'h1);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'hFFEE, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0);
    check("core_wdt", 32'(bus.arb_dm_wdt), 32'hFFEE);
    check("core_stall", 32'(bus.arb_ps_stall), 32'h0);

    // Host read with the core idle: issue at N+1, ack with data at N+2
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h0000F, 16'h0, 16'h0);
    check("hrd_n_stall", 32'(bus.arb_ps_stall), 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h0000F, 16'h0, 16'h0);
    check("hrd_issue_stall", 32'(bus.arb_ps_stall), 32'h1);
    check("hrd_issue_add", 32'(bus.arb_dm_add), 32'h0000F);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h0000F, 16'h0, 16'h1234);
    check("hrd_ack", 32'(bus.hst_ack), 32'h1);
    check("hrd_rdt", 32'(bus.hst_rdt), 32'h1234);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0);

    // Starvation with core writing every cycle; host write 0xBEEF lands after the last core write
    grants = 0; seen = 1'b0; bc = '0;
    for (int k = 0; k < 20 && !seen; k++) begin
      bc = DW'($urandom);
      drive_cycle(1'b0, 1'b1, 1'b1, AW'(k), bc, 1'b1, 1'b1, 17'h00123, 16'hBEEF, 16'h5555);
      if (bus.arb_ps_stall) begin
        seen = 1'b1;
        check("handover_core_wdt", 32'(bus.arb_dm_wdt), 32'(bc));
      end else begin
        grants++;
      end
    end
    check("starve_issue_seen", 32'(seen), 32'h1);
    check("starve_grants", 32'(grants), 32'(SM));
    drive_cycle(1'b0, 1'b1, 1'b0, 17'h0, 16'h1111, 1'b1, 1'b1, 17'h00123, 16'hBEEF, 16'h5555);
    check("handover_host_wdt", 32'(bus.arb_dm_wdt), 32'hBEEF);
    check("starve_ack", 32'(bus.hst_ack), 32'h1);
    check("hwr_rdt_zero", 32'(bus.hst_rdt), 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0);

    // Reset arriving during the host issue cycle abandons the access
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h0);
    check("rst_mid_pre_stall", 32'(bus.arb_ps_stall), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(bus.arb_ps_stall), 32'h0);
    check("rst_mid_cslt", 32'(bus.arb_dm_cslt), 32'h0);
    drive_cycle(1'b1, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h7777);
    check("rst_mid_ack", 32'(bus.hst_ack), 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h7777);
    check("rereq_no_ack", 32'(bus.hst_ack), 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h7777);
    check("rereq_issue", 32'(bus.arb_ps_stall), 32'h1);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h7777);
    check("rereq_rdt", 32'(bus.hst_rdt), 32'h7777);

    // Back-to-back: request held through the ack, core takes the cycle in between
    drive_cycle(1'b0, 1'b1, 1'b0, 17'h00042, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h0);
    check("b2b_core_grant", 32'(bus.arb_dm_add), 32'h00042);
    check("b2b_core_stall", 32'(bus.arb_ps_stall), 32'h0);
    gap = 1; seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h0);
      gap++;
      seen = bus.arb_ps_stall;
    end
    check("b2b_issue_seen", 32'(seen), 32'h1);
    check("b2b_gap_ok", 32'(gap >= 2), 32'h1);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 17'h00055, 16'h0, 16'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0);

    // Random traffic with varying core load and rare resets
    h_pend = 1'b0; h_wr = 1'b0; h_add = '0; h_wd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (h_pend && ack_seen) begin
        if ($urandom_range(1, 0) == 0) begin
          h_pend = 1'b0;
        end else begin
          h_wr = 1'($urandom_range(1, 0)); h_add = AW'($urandom); h_wd = DW'($urandom);
        end
      end else if (!h_pend && $urandom_range(3, 0) == 0) begin
        h_pend = 1'b1;
        h_wr = 1'($urandom_range(1, 0)); h_add = AW'($urandom); h_wd = DW'($urandom);
      end
      r = ($urandom_range(299, 0) == 0);
      if (i < 500) seen = ($urandom_range(1, 0) == 0);
      else if (i < 1000) seen = ($urandom_range(9, 0) != 0);
      else seen = ($urandom_range(4, 0) == 0);
      drive_cycle(r, seen, 1'($urandom_range(1, 0)), AW'($urandom), DW'($urandom),
                  h_pend, h_wr, h_add, h_wd, DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
